// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-ported register file.
// - Two write ports. When both ports write the same address, wr1 wins.
// - NUM_RD registered read ports with write-first bypass and a latency of one cycle.
// - A sequential clear that zeroes one register per cycle, reported through busy and clr_done.
// - Optional macro REGFILE_ZERO_REG_EN makes register 0 read as zero and ignore writes.
module reg_file_mp #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
  input  logic                           wr0_en,
  input  logic [ADDR_WIDTH-1:0]          wr0_addr,
  input  logic [DATA_WIDTH-1:0]          wr0_data,
  input  logic                           wr1_en,
  input  logic [ADDR_WIDTH-1:0]          wr1_addr,
  input  logic [DATA_WIDTH-1:0]          wr1_data,
  input  logic                           clr_req,
  output logic                           busy,
  output logic                           clr_done,
  output logic                           wr_drop
);

  localparam int                     DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR = '1;
  localparam logic [ADDR_WIDTH-1:0]  CNT_ONE   = ADDR_WIDTH'(1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                   state;
  logic [ADDR_WIDTH-1:0]    clr_cnt;
  logic [DATA_WIDTH-1:0]    regs [DEPTH];

  logic                     wr0_live;
  logic                     wr1_live;
  logic                     same_addr;
  logic                     wr0_ok;
  logic                     wr1_ok;
  logic                     wr_conflict;
  logic                     drop_p0;
  logic [NUM_RD*DATA_WIDTH-1:0] rd_next_p0;

`ifdef REGFILE_ZERO_REG_EN
  // Register 0 is hard-wired to zero. Writes to it vanish without a drop report.
  assign wr0_live = (wr0_addr != '0);
  assign wr1_live = (wr1_addr != '0);
`else
  assign wr0_live = 1'b1;
  assign wr1_live = 1'b1;
`endif

  // Arbitration: writes are accepted only outside a clear. On an address collision, wr1 wins.
  assign same_addr   = (wr0_addr == wr1_addr);
  assign wr_conflict = !busy && wr0_en && wr1_en && same_addr && wr1_live;
  assign wr0_ok      = !busy && wr0_en && wr0_live && !(wr1_en && same_addr);
  assign wr1_ok      = !busy && wr1_en && wr1_live;
  assign drop_p0     = busy ? (wr0_en | wr1_en) : wr_conflict;

  // Value a register will hold after the coming edge.
  // A clear of that address takes priority over writes, and wr1 takes priority over wr0.
  function automatic logic [DATA_WIDTH-1:0] read_next(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] cur
  );
    logic [DATA_WIDTH-1:0] v;
    if (busy && (a == clr_cnt))
      v = '0;
    else if (wr1_ok && (a == wr1_addr))
      v = wr1_data;
    else if (wr0_ok && (a == wr0_addr))
      v = wr0_data;
    else
      v = cur;
`ifdef REGFILE_ZERO_REG_EN
    if (a == '0)
      v = '0;
`endif
    return v;
  endfunction

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    assign ra = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign rd_next_p0[k*DATA_WIDTH +: DATA_WIDTH] = read_next(ra, regs[ra]);
  end

  // ---- stage p0 -> p1: register array update (clear has priority, no writes while busy)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else if (busy) begin
      regs[clr_cnt] <= '0;
    end else begin
      if (wr0_ok)
        regs[wr0_addr] <= wr0_data;
      if (wr1_ok)
        regs[wr1_addr] <= wr1_data;
    end
  end

  // Clear sequencer: IDLE waits for clr_req, and CLEAR walks the counter from 0 to the last address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      clr_done <= 1'b0;
      clr_cnt  <= '0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clr_req) begin
            state   <= ST_CLEAR;
            busy    <= 1'b1;
            clr_cnt <= '0;
          end
        end
        ST_CLEAR: begin
          if (clr_cnt == LAST_ADDR) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            clr_done <= 1'b1;
            clr_cnt  <= '0;
          end else begin
            clr_cnt <= clr_cnt + CNT_ONE;
          end
        end
      endcase
    end
  end

  // ---- stage p0 -> p1: registered read data and drop pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
      wr_drop <= 1'b0;
    end else begin
      rd_data <= rd_next_p0;
      wr_drop <= drop_p0;
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp. It uses a behavioural array model plus hand-computed literal checks.
module tb_reg_file_mp;

  localparam int DW    = 16;
  localparam int AW    = 5;
  localparam int NR    = 3;
  localparam int DEPTH = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic              wr0_en, wr1_en;
  logic [AW-1:0]     wr0_addr, wr1_addr;
  logic [DW-1:0]     wr0_data, wr1_data;
  logic              clr_req;
  logic              busy, clr_done, wr_drop;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .clr_req(clr_req), .busy(busy), .clr_done(clr_done), .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_regs [DEPTH];
  logic [DW-1:0] m_rd [NR];
  bit            m_busy, m_done, m_drop;
  int            m_cnt;

  function automatic bit writable(input logic [AW-1:0] a);
`ifdef REGFILE_ZERO_REG_EN
    return a != '0;
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
      for (int k = 0; k < NR; k++) m_rd[k] = '0;
      m_busy = 0; m_done = 0; m_drop = 0; m_cnt = 0;
    end else begin
      m_done = 0;
      m_drop = 0;
      if (m_busy) begin
        if (wr0_en || wr1_en) m_drop = 1;
        m_regs[m_cnt] = '0;
        if (m_cnt == DEPTH - 1) begin
          m_busy = 0; m_done = 1; m_cnt = 0;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end else begin
        // apply in order: a later write to the same address overrides
        if (wr0_en && writable(wr0_addr)) m_regs[wr0_addr] = wr0_data;
        if (wr1_en && writable(wr1_addr)) begin
          if (wr0_en && (wr0_addr == wr1_addr)) m_drop = 1;
          m_regs[wr1_addr] = wr1_data;
        end
        if (clr_req) begin m_busy = 1; m_cnt = 0; end
      end
      for (int k = 0; k < NR; k++) begin
        logic [AW-1:0] a;
        a = rd_addr[k*AW +: AW];
        m_rd[k] = writable(a) ? m_regs[a] : '0;
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] port(input int k);
    return rd_data[k*DW +: DW];
  endfunction

  // compare DUT against model every cycle, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < NR; k++)
        chk($sformatf("model_rd%0d", k), port(k), m_rd[k]);
      chk1("model_busy", busy, m_busy);
      chk1("model_clr_done", clr_done, m_done);
      chk1("model_wr_drop", wr_drop, m_drop);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_wr();
    wr0_en = 0; wr1_en = 0; clr_req = 0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    rd_addr = {a2, a1, a0};
  endtask

  initial begin
    int n;
    rst_n = 0;
    idle_wr();
    wr0_addr = '0; wr1_addr = '0; wr0_data = '0; wr1_data = '0;
    set_rd(0, 0, 0);
    repeat (3) step();

    // reset state
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_clr_done", clr_done, 1'b0);
    chk1("rst_wr_drop", wr_drop, 1'b0);
    for (int k = 0; k < NR; k++) chk($sformatf("rst_rd%0d", k), port(k), 16'h0000);

    rst_n = 1;
    cmp_en = 1;
    step();

    // write 5 <- 1234, then read it back on port 0
    wr0_en = 1; wr0_addr = 5; wr0_data = 16'h1234;
    step();
    idle_wr(); set_rd(5, 0, 0);
    step();
    chk("rd_after_write", port(0), 16'h1234);

    // same-address conflict: wr1 wins, one drop pulse
    wr0_en = 1; wr0_addr = 7; wr0_data = 16'hAAAA;
    wr1_en = 1; wr1_addr = 7; wr1_data = 16'h5555;
    set_rd(5, 7, 0);
    step();
    idle_wr();
    chk1("conflict_drop", wr_drop, 1'b1);
    chk("conflict_bypass", port(1), 16'h5555);
    step();
    chk1("conflict_drop_once", wr_drop, 1'b0);
    chk("conflict_reg7", port(1), 16'h5555);

    // write 3 while every port reads 3 in the same cycle
    wr0_en = 1; wr0_addr = 3; wr0_data = 16'hBEEF;
    set_rd(3, 3, 3);
    step();
    idle_wr();
    for (int k = 0; k < NR; k++) chk($sformatf("bypass_rd%0d", k), port(k), 16'hBEEF);

    // two writes to distinct addresses in one cycle
    wr0_en = 1; wr0_addr = 10; wr0_data = 16'h0A0A;
    wr1_en = 1; wr1_addr = 11; wr1_data = 16'h0B0B;
    set_rd(10, 11, 12);
    step();
    idle_wr();
    chk1("dual_no_drop", wr_drop, 1'b0);
    chk("dual_rd0", port(0), 16'h0A0A);
    chk("dual_rd1", port(1), 16'h0B0B);

    // fill all registers
    for (int i = 0; i < DEPTH / 2; i++) begin
      wr0_en = 1; wr0_addr = AW'(2*i);     wr0_data = 16'hA000 | 16'(2*i);
      wr1_en = 1; wr1_addr = AW'(2*i + 1); wr1_data = 16'hB000 | 16'(2*i + 1);
      step();
    end
    idle_wr();
    set_rd(17, 2, 30);
    step();
    chk("fill_rd17", port(0), 16'hB011);
    chk("fill_rd2", port(1), 16'hA002);

    // sequential clear with a dropped write and an ignored clr_req in the middle
    clr_req = 1;
    step();
    clr_req = 0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (n == 1) set_rd(0, 31, 1);
      if (n == 5) begin wr0_en = 1; wr0_addr = 31; wr0_data = 16'h7777; end
      if (n == 6) begin chk1("busy_wr_drop", wr_drop, 1'b1); wr0_en = 0; end
      if (n == 7) begin
        chk("clear_pending31", port(1), 16'hB01F);
        chk("clear_done0", port(0), 16'h0000);
      end
      if (n == 8) clr_req = 1;
      if (n == 9) clr_req = 0;
      step();
    end
    chk("busy_cycles", 16'(n), 16'd32);
    chk1("clr_done_pulse", clr_done, 1'b1);
    chk1("busy_after_clear", busy, 1'b0);
    chk("cleared31", port(1), 16'h0000);
    step();
    chk1("clr_done_single", clr_done, 1'b0);
    for (int a = 0; a < DEPTH; a += NR) begin
      set_rd(AW'(a), AW'((a + 1) % DEPTH), AW'((a + 2) % DEPTH));
      step();
    end
    chk("cleared17", port(0), 16'h0000);

    // reset in the middle of a clear
    wr0_en = 1; wr0_addr = 20; wr0_data = 16'h2020;
    wr1_en = 1; wr1_addr = 21; wr1_data = 16'h2121;
    set_rd(20, 21, 0);
    step();
    idle_wr();
    clr_req = 1;
    step();
    clr_req = 0;
    repeat (9) step();
    chk1("clear_busy_before_rst", busy, 1'b1);
    rst_n = 0;
    #1;
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_clr_done", clr_done, 1'b0);
    for (int k = 0; k < NR; k++) chk($sformatf("abort_rd%0d", k), port(k), 16'h0000);
    step();
    chk1("abort_no_done", clr_done, 1'b0);
    rst_n = 1;
    step();
    chk("abort_reg20", port(0), 16'h0000);
    chk("abort_reg21", port(1), 16'h0000);
    chk1("abort_no_done2", clr_done, 1'b0);

    // normal operation right after reset, including address 0
    wr0_en = 1; wr0_addr = 9; wr0_data = 16'h0909;
    wr1_en = 1; wr1_addr = 0; wr1_data = 16'hFFFF;
    set_rd(9, 0, 0);
    step();
    idle_wr();
    chk("post_rst_reg9", port(0), 16'h0909);
    chk1("addr0_no_drop", wr_drop, 1'b0);
`ifdef REGFILE_ZERO_REG_EN
    chk("zero_reg_rd", port(1), 16'h0000);
`else
    chk("addr0_rd", port(1), 16'hFFFF);
`endif
    step();
    chk1("addr0_no_drop_later", wr_drop, 1'b0);
    step();

    cmp_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
